// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1/8N2 UART transmitter with a small write FIFO, paced by the
//            shared 8x-oversample baud tick. Back-to-back frames, no idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baudtick8,
    input  logic [7:0] tx_data,
    input  logic       tx_write,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);

    localparam int                 c_ptr_w     = $clog2(FIFO_DEPTH);
    localparam int                 c_cnt_w     = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
    localparam logic [2:0]         c_stop_last = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_next;
    logic               r_full;
    logic               r_empty;
    logic [2:0]         r_bit_timer;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_next;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_next;
    logic               r_tx;
    logic               w_tx_next;
    logic               w_write;
    logic               w_pop;
    logic               w_done;
    logic               w_bit_end;

    // ------------------------------------------------------------------
    // Write FIFO: status flags are registered from the post-update count
    // ------------------------------------------------------------------
    assign w_write = tx_write && !r_full;

    always_comb begin
        w_count_next = r_count;
        case ({w_write, w_pop})
            2'b10:   w_count_next = r_count + c_cnt_one;
            2'b01:   w_count_next = r_count - c_cnt_one;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_depth);
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // ------------------------------------------------------------------
    // Bit timer: 8 baud ticks per bit, re-phased on every pop
    // ------------------------------------------------------------------
    assign w_bit_end = baudtick8 && (r_bit_timer == 3'd7);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_timer <= '0;
        end else if (w_pop) begin
            r_bit_timer <= '0;
        end else if (baudtick8 && (r_state != S_IDLE)) begin
            r_bit_timer <= r_bit_timer + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_tx_next      = r_tx;
        w_pop          = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (!r_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_tx_next    = 1'b0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_tx_next      = r_shift[0];
                    w_bit_idx_next = '0;
                    w_state_next   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_tx_next      = 1'b1;
                        w_bit_idx_next = '0;
                        w_state_next   = S_STOP;
                    end else begin
                        w_tx_next      = r_shift[1];
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_idx == c_stop_last) begin
                        w_done         = 1'b1;
                        w_bit_idx_next = '0;
                        // Chain straight into the next start bit when data is waiting
                        if (!r_empty) begin
                            w_pop        = 1'b1;
                            w_shift_next = r_mem[r_rd_ptr];
                            w_tx_next    = 1'b0;
                            w_state_next = S_START;
                        end else begin
                            w_tx_next    = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_tx_next    = 1'b1;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    assign tx       = r_tx;
    assign tx_busy  = (r_state != S_IDLE);
    assign tx_done  = w_done;
    assign tx_full  = r_full;
    assign tx_empty = r_empty;

endmodule
`default_nettype wire
